// File: rtl/i2c_pkg.sv
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared types and constants for the write-only I2C master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR1 = 3'd2,
        ADDR2 = 3'd3,
        DATA  = 3'd4,
        ACK   = 3'd5,
        STOP  = 3'd6
    } state_t;

    typedef logic [1:0] phase_t;

    localparam logic [4:0] ADDR10_PREFIX = 5'b11110;

    // First address byte on the wire; R/W is always 0 (write).
    function automatic logic [7:0] addr_byte1(input logic [9:0] addr, input logic mode10);
        return mode10 ? {ADDR10_PREFIX, addr[9:8], 1'b0} : {addr[6:0], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_scl_divider.sv
// ============================================================================
// Module  : i2c_scl_divider
// Brief   : Quarter-period tick generator with synchronous clear and hold.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_scl_divider #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    input  logic hold_i,
    output logic qtick_o
);

    localparam int            CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (!hold_i) begin
            cnt_q <= (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign qtick_o = (cnt_q == C_LAST) && !hold_i && !clr_i;

endmodule

`default_nettype wire

// File: rtl/i2c_master_tx.sv
// ============================================================================
// Module  : i2c_master_tx
// Brief   : Write-only I2C master: START, 7/10-bit address, N data bytes, STOP.
//           Optional SCL clock stretching when I2C_CLOCK_STRETCH_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       SDA_sync,
    input  logic       SCL_sync,
    input  logic       cmd_start,
    input  logic [9:0] bus_address,
    input  logic       address_mode,
    input  logic [7:0] num_bytes,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       SDA_out,
    output logic       SCL_out
);

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    phase_t     phase_q, phase_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [9:0] addr_q, addr_d;
    logic       mode10_q, mode10_d;
    logic       nack_seen_q, nack_seen_d;
    logic       load_q, load_d;
    logic       done_q, done_d;
    logic       nack_q, nack_d;
    logic       w_qtick;
    logic       w_hold;
    logic       w_end_q;

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the high phase.
    assign w_hold = SCL_out && !SCL_sync && phase_q[1];
`else
    assign w_hold = 1'b0;
    wire unused_scl_sync = SCL_sync;
`endif

    i2c_scl_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (state_q == IDLE),
        .hold_i  (w_hold),
        .qtick_o (w_qtick)
    );

    assign w_end_q  = w_qtick && (phase_q == 2'd3);
    assign tx_ready = load_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign nack     = nack_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            phase_q     <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            mode10_q    <= 1'b0;
            nack_seen_q <= 1'b0;
            load_q      <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            phase_q     <= phase_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            mode10_q    <= mode10_d;
            nack_seen_q <= nack_seen_d;
            load_q      <= load_d;
            done_q      <= done_d;
            nack_q      <= nack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        phase_d     = w_qtick ? phase_q + 2'd1 : phase_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        mode10_d    = mode10_q;
        nack_seen_d = nack_seen_q;
        load_d      = 1'b0;
        done_d      = 1'b0;
        nack_d      = 1'b0;
        SDA_out     = 1'b1;
        SCL_out     = 1'b1;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (cmd_start) begin
                    state_d    = START;
                    addr_d     = bus_address;
                    mode10_d   = address_mode;
                    byte_cnt_d = num_bytes;
                end
            end
            START: begin
                SDA_out = !phase_q[1];
                SCL_out = (phase_q != 2'd3);
                if (w_end_q) begin
                    state_d   = ADDR1;
                    shift_d   = addr_byte1(addr_q, mode10_q);
                    bit_cnt_d = '0;
                end
            end
            ADDR1, ADDR2, DATA: begin
                SCL_out = phase_q[1];
                // The new byte is not in the shifter yet on its load cycle.
                SDA_out = load_q ? tx_data[7] : shift_q[7];
                if (load_q) begin
                    shift_d    = tx_data;
                    byte_cnt_d = byte_cnt_q - 8'd1;
                end
                if (w_end_q) begin
                    if (bit_cnt_q == 4'd7) begin
                        state_d     = ACK;
                        ret_d       = state_q;
                        nack_seen_d = 1'b0;
                        bit_cnt_d   = '0;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK: begin
                SCL_out = phase_q[1];
                if (w_qtick && (phase_q == 2'd2) && SDA_sync) begin
                    nack_seen_d = 1'b1;
                    nack_d      = 1'b1;
                end
                if (w_end_q) begin
                    if (nack_seen_q) begin
                        state_d = STOP;
                    end else if ((ret_q == ADDR1) && mode10_q) begin
                        state_d = ADDR2;
                        shift_d = addr_q[7:0];
                    end else if (byte_cnt_q != 8'd0) begin
                        state_d = DATA;
                        load_d  = 1'b1;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                SDA_out = phase_q[1];
                SCL_out = (phase_q != 2'd0);
                if (w_end_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
